a2f_sync_fifo: RTL and testbench
================================

# a2f_sync_fifo

Single-clock synchronous FIFO that buffers received AFE IQ sample pairs on their way to the FT600 USB writer. It sits between the AFE receive path (writer) and the `sel_a2f` packet selector (reader). It exposes `empty`, `full` and a packet-ready `almost_full` flag. `almost_full` means "at least one FT packet of words is buffered".

## Interface
- `DATA_WIDTH`, default 24: width of one IQ pair word.
- `DEPTH`, default 128: number of storage words; must be a power of two and at least 4.
- `AF_LEVEL`, default 32: fill level at which `almost_full` asserts (one FT packet). Legal range is 1..DEPTH.
- `clk`  in  1  single clock for all logic; rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `data`  in  DATA_WIDTH  write word.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request.
- `q`  out  DATA_WIDTH  read word.
- `empty`  out  1  level == 0.
- `full`  out  1  level == DEPTH.
- `almost_full`  out  1  level >= AF_LEVEL.
- `level`  out  $clog2(DEPTH)+1  current word count.

## Operation
- Reset (`reset_n` low at a rising edge):
  - write and read pointers go to 0, `level` = 0.
  - `q` = 0, `empty` = 1, `full` = 0, `almost_full` = 0.
  - memory contents are not cleared.
- Write acceptance: a write is accepted when `wr_en` && !`full`.
  - `data` is stored at the write pointer and the write pointer increments modulo DEPTH.
  - A write while `full` is dropped silently, even if a read is accepted in the same cycle.
- Read acceptance: a read is accepted when `rd_en` && !`empty`.
  - `q` loads the word at the read pointer and the read pointer increments modulo DEPTH.
  - A read while `empty` is ignored and `q` holds its value, even if a write is accepted in the same cycle.
- `q` holds its last value whenever no read is accepted.
- Level update:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - unchanged when both or neither are accepted.
- Ordering is strict FIFO; no word is lost or duplicated across pointer wrap-around.
- All flags are registered and derived from the next-state level. They are therefore valid in the cycle right after the edge that changed the level.

## Timing
- Read latency is 1 cycle: with `rd_en` high at edge N, the word is on `q` after edge N.
- Write-to-empty deassert is 1 cycle: the first accepted write at edge N gives `empty` = 0 after edge N. A read may be issued at edge N+1.
- `full` asserts after the edge that accepts write number DEPTH. It deasserts after the first accepted read.
- `almost_full`:
  - asserts after the edge where `level` reaches AF_LEVEL.
  - deasserts after the edge where `level` drops to AF_LEVEL−1.
  - has no hysteresis.
- Simultaneous read+write at `level` in 1..DEPTH−1: both are accepted and the level is unchanged.
- Simultaneous read+write at `level` 0: only the write is accepted, level becomes 1, `q` is unchanged.
- Simultaneous read+write at `level` DEPTH: only the read is accepted, level becomes DEPTH−1.
- Reset mid-operation: stored data is discarded. Inputs sampled in the reset cycle are ignored.

## Structure
- Shared package `sdr_pkg` holds:
  - `IQ_PAIR_WIDTH` = 24.
  - `A2F_FIFO_WORDS` = 128.
  - `FT_PACKET_WORDS` = 32.
  - an `iq_pair_t` typedef of logic [23:0].
- Top-level instantiation uses these constants as the parameter values.
- Storage is one natural sub-module, `a2f_fifo_mem`: a simple dual-port RAM with registered synchronous read, one write port and one read port, inferred as EBR.
  - Control (pointers, level, flags) lives in `a2f_sync_fifo` itself.
  - The RAM read-enable is the accepted-read strobe, so `q` is the RAM output register.

## Test plan
- **Reset.** Hold `reset_n` low for 2 cycles with `wr_en` = `rd_en` = 1, then release.
  - Expect `empty` = 1, `full` = 0, `almost_full` = 0, `level` = 0, `q` = 0.
- **Fill to full.** Write 0x000001..0x000080 on consecutive cycles.
  - `almost_full` rises after the 32nd write.
  - `full` rises after the 128th write.
  - A 129th write of 0xDEAD00 is dropped and `level` stays 128.
- **Drain.** From the full state, read 128 times.
  - `q` sequence is 0x000001..0x000080, each 1 cycle after its `rd_en`.
  - `almost_full` falls after the read that leaves level 31; `empty` rises after the last read.
  - An extra read leaves `q` = 0x000080.
- **Wrap-around streaming.** Pre-load 10 words, then assert `wr_en` and `rd_en` together for 300 cycles with incrementing data.
  - `level` stays 10.
  - Output sequence is exactly the input sequence, with pointers wrapping twice.
- **Boundary simultaneity.**
  - At level 0, read+write of 0x123456: level becomes 1, `q` is unchanged, and a read next cycle gives 0x123456.
  - At level 128, read+write: level becomes 127 and the write is dropped.
- **Reset mid-stream.** At level 50, pulse `reset_n` low for 1 cycle.
  - Flags return to reset values.
  - The next write of 0xABCDEF is read back first.

Source files
------------

// File: rtl/sdr_pkg.sv
// sdr_pkg: constants and types shared by the SDR receive chain.
// The AFE-to-FT600 FIFO takes its default word width, depth and packet
// threshold from here.
package sdr_pkg;

  localparam int IQ_PAIR_WIDTH   = 24;   // one I/Q sample pair
  localparam int A2F_FIFO_WORDS  = 128;  // AFE->FT600 FIFO depth
  localparam int FT_PACKET_WORDS = 32;   // words in one FT600 packet

  typedef logic [IQ_PAIR_WIDTH-1:0] iq_pair_t;

endpackage

// File: rtl/a2f_sync_fifo_if.sv
// a2f_sync_fifo_if: write/read bus of the AFE->FT600 FIFO.
//   master: the user side. It drives data/wr_en/rd_en and sees q and the
//           status outputs (empty, full, almost_full, level).
//   slave : the FIFO side.
interface a2f_sync_fifo_if
  import sdr_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_PAIR_WIDTH,
  parameter int DEPTH      = A2F_FIFO_WORDS
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] q;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [LW-1:0]         level;

  modport master (
    output data, wr_en, rd_en,
    input  q, empty, full, almost_full, level
  );

  modport slave (
    input  data, wr_en, rd_en,
    output q, empty, full, almost_full, level
  );
endinterface

// File: rtl/a2f_fifo_mem.sv
// a2f_fifo_mem: simple dual-port RAM, one write port and one read port.
// The read is synchronous and registered, so the block maps onto EBR with
// its output register. Only the output register is reset; the array is not.
// Ports:
//   clk_i, rst_n_i     clock, synchronous active-low reset (output register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read port; rdata_o loads only when re_i is high
//   rdata_o            registered read data
module a2f_fifo_mem #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The output register holds its value between reads. The FIFO's q is
  // this register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/a2f_sync_fifo.sv
// a2f_sync_fifo: single-clock FIFO between the AFE receive path and the
// FT600 packet selector.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      a2f_sync_fifo_if.slave: data/wr_en/rd_en in,
//            q/empty/full/almost_full/level out
// Control state (pointers, level, flags) lives here. Storage lives in
// a2f_fifo_mem. The flags are registered from the next-state level, so
// they are valid right after the edge that changes the level.
module a2f_sync_fifo
  import sdr_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_PAIR_WIDTH,
  parameter int DEPTH      = A2F_FIFO_WORDS,
  parameter int AF_LEVEL   = FT_PACKET_WORDS
) (
  input logic             clk,
  input logic             reset_n,
  a2f_sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, full_q, af_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered flags. A write while full is dropped
  // even if a read frees a slot in the same cycle. A read while empty is
  // ignored even if a write arrives. Gating with reset_n keeps the inputs
  // of the reset cycle away from the RAM.
  assign wr_acc = bus.wr_en && !full_q  && reset_n;
  assign rd_acc = bus.rd_en && !empty_q && reset_n;

  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_acc) rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LW'(DEPTH));
      af_q    <= (level_d >= LW'(AF_LEVEL));
    end
  end

  a2f_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.data),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (bus.q)
  );

  assign bus.level       = level_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
endmodule

// File: tb/tb_a2f_sync_fifo.sv
module tb_a2f_sync_fifo;
  import sdr_pkg::*;

  localparam int DW    = IQ_PAIR_WIDTH;
  localparam int DEPTH = A2F_FIFO_WORDS;
  localparam int AF    = FT_PACKET_WORDS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  a2f_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  a2f_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model of the FIFO. Acceptance is decided from the occupancy
  // before the edge, and then the pop and the push are applied.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q;
  bit            armed = 0;

  always @(posedge clk) begin
    bit wa, ra;
    if (!reset_n) begin
      mq.delete();
      m_q   = '0;
      armed = 1;
    end else if (armed) begin
      wa = bus.wr_en && (mq.size() < DEPTH);
      ra = bus.rd_en && (mq.size() > 0);
      if (ra) m_q = mq.pop_front();
      if (wa) mq.push_back(bus.data);
    end
  end

  // Each cycle, compare the DUT outputs with the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_q",     bus.q,           m_q);
      chk("cmp_level", bus.level,       mq.size());
      chk("cmp_empty", bus.empty,       mq.size() == 0);
      chk("cmp_full",  bus.full,        mq.size() == DEPTH);
      chk("cmp_af",    bus.almost_full, mq.size() >= AF);
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.data  = 24'h000000;
    reset_n   = 1'b0;
    // Hold reset for two cycles with both requests high.
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full, 0);
    chk("rst_af",    bus.almost_full, 0);
    chk("rst_q",     bus.q, 0);

    // Fill to full.
    for (int i = 1; i <= 128; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      if (i == 1)   chk("fill_empty1", bus.empty, 0);
      if (i == 31)  chk("fill_af31", bus.almost_full, 0);
      if (i == 32)  begin chk("fill_af32", bus.almost_full, 1); chk("fill_lvl32", bus.level, 32); end
      if (i == 127) chk("fill_full127", bus.full, 0);
      if (i == 128) chk("fill_full128", bus.full, 1);
    end
    cyc(1'b1, 1'b0, 24'hDEAD00);
    chk("drop_level", bus.level, 128);
    chk("drop_full",  bus.full, 1);

    // Drain. Expect the words in write order, with the dropped one absent.
    for (int i = 1; i <= 128; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("drain_q", bus.q, i);
      if (i == 1)   chk("drain_full", bus.full, 0);
      if (i == 96)  chk("drain_af32", bus.almost_full, 1);
      if (i == 97)  chk("drain_af31", bus.almost_full, 0);
      if (i == 127) chk("drain_empty127", bus.empty, 0);
      if (i == 128) chk("drain_empty", bus.empty, 1);
    end
    cyc(1'b0, 1'b1, '0);
    chk("extra_rd_q", bus.q, 24'h000080);
    chk("extra_rd_level", bus.level, 0);

    // Wrap-around streaming: 310 writes starting at pointer 0 wrap twice.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 24'h100000 + DW'(k));
    chk("pre_level", bus.level, 10);
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b1, 24'h100000 + DW'(k + 10));
      chk("stream_q", bus.q, 24'h100000 + k);
      chk("stream_level", bus.level, 10);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, '0);
      chk("tail_q", bus.q, 24'h100000 + 300 + k);
    end
    chk("tail_empty", bus.empty, 1);

    // Read and write together at level 0: only the write is taken.
    cyc(1'b1, 1'b1, 24'h123456);
    chk("b0_level", bus.level, 1);
    chk("b0_q_hold", bus.q, 24'h100135);
    cyc(1'b0, 1'b1, '0);
    chk("b0_q", bus.q, 24'h123456);
    chk("b0_empty", bus.empty, 1);

    // Read and write together at level DEPTH: only the read is taken.
    for (int k = 0; k < 128; k++) cyc(1'b1, 1'b0, 24'h200000 + DW'(k));
    chk("bf_full", bus.full, 1);
    cyc(1'b1, 1'b1, 24'hBAD000);
    chk("bf_level", bus.level, 127);
    chk("bf_q", bus.q, 24'h200000);
    for (int k = 1; k < 128; k++) begin
      cyc(1'b0, 1'b1, '0);
      chk("bf_drain_q", bus.q, 24'h200000 + k);
    end
    chk("bf_drain_empty", bus.empty, 1);

    // Reset in the middle of a stream.
    for (int k = 0; k < 50; k++) cyc(1'b1, 1'b0, 24'h300000 + DW'(k));
    chk("mid_level", bus.level, 50);
    chk("mid_af", bus.almost_full, 1);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 24'h555555);
    reset_n = 1'b1;
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_af", bus.almost_full, 0);
    chk("mid_rst_full", bus.full, 0);
    chk("mid_rst_q", bus.q, 0);
    cyc(1'b1, 1'b0, 24'hABCDEF);
    cyc(1'b0, 1'b1, '0);
    chk("mid_rdback_q", bus.q, 24'hABCDEF);
    chk("mid_rdback_empty", bus.empty, 1);

    cyc(1'b0, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
